instr_encoder_loader: RTL and testbench

//  Write-side counterpart of the instruction decoder. Accepts instruction fields over a

---
 rtl/instr_encoder_loader_if.sv | 27 ++
 rtl/instr_encoder_loader.sv | 100 ++++++++++
 tb/tb_instr_encoder_loader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: field stream in, instruction-memory write bus out.
//  master: producer of field tuples and owner of the memory (drives in_*, mem_ready)
//  slave : the loader (drives in_ready, mem_we, mem_addr, mem_wdata)
interface instr_encoder_loader_if #(parameter int ADDR_W = 8) ();
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        in_opcode;
  logic [2:0]        in_rd;
  logic [2:0]        in_rs;
  logic [2:0]        in_rt;
  logic [2:0]        in_func;
  logic [5:0]        in_imm;
  logic [8:0]        in_offset;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  modport master (
    output in_valid, in_last, in_opcode, in_rd, in_rs, in_rt, in_func, in_imm, in_offset, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  in_valid, in_last, in_opcode, in_rd, in_rs, in_rt, in_func, in_imm, in_offset, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs instruction fields into 16-bit words, buffers them and writes them to instruction memory.
//  clk, reset (sync, active-high), start (pulse, IDLE only)
//  bus       : field stream (valid/ready/last) and memory write port (we/ready/addr/wdata)
//  busy      : high in LOAD and DRAIN;  done: one-cycle completion pulse
//  count     : words written since start (saturating);  addr_wrap: sticky address wrap flag
//  Optional LOADER_CHECKSUM_EN adds checksum = XOR of words written since start.
module instr_encoder_loader #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_encoder_loader_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     count,
  output logic                addr_wrap
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]         checksum
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  logic [1:0]        r_state;
  logic [15:0]       r_fifo [DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [PW:0]       r_occ;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_wrap;
  logic              w_full, w_empty, w_push, w_pop;
  logic [15:0]       w_word;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       r_csum;
  assign checksum = r_csum;
`endif
  always_comb
    w_word = bus.in_opcode == 4'b0000 ? {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_rt, bus.in_func} :
             bus.in_opcode == 4'b0001 ? {bus.in_opcode, bus.in_offset, bus.in_func} :
                                        {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_imm};
  assign w_full        = r_occ == (PW+1)'(DEPTH);
  assign w_empty       = r_occ == '0;
  // in_ready ignores a same-cycle pop so a full FIFO never needs a bypass path
  assign bus.in_ready  = r_state == S_LOAD && !w_full;
  assign bus.mem_we    = (r_state == S_LOAD || r_state == S_DRAIN) && !w_empty;
  assign bus.mem_wdata = w_empty ? '0 : r_fifo[r_rp];
  assign bus.mem_addr  = r_addr;
  assign w_push        = bus.in_valid && bus.in_ready;
  assign w_pop         = bus.mem_we && bus.mem_ready;
  assign busy          = r_state == S_LOAD || r_state == S_DRAIN;
  assign done          = r_state == S_DONE;
  assign count         = r_count;
  assign addr_wrap     = r_wrap;
  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wp] <= w_word;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_occ   <= '0;
      r_addr  <= BASE_ADDR;
      r_count <= '0;
      r_wrap  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_occ <= r_occ + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_pop) begin
        r_addr <= r_addr + 1'b1;
        if (&r_addr) r_wrap <= 1'b1;
        if (!(&r_count)) r_count <= r_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        r_csum <= r_csum ^ bus.mem_wdata;
`endif
      end
      case (r_state)
        S_IDLE:
          if (start) begin
            r_state <= S_LOAD;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_wrap  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        S_LOAD:  if (w_push && bus.in_last) r_state <= S_DRAIN;
        S_DRAIN: if (w_empty) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of packing, ordering, back-pressure, address wrap and reset.
module tb_instr_encoder_loader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic v = 1'b0, last = 1'b0, mr = 1'b1;
  logic [3:0] op = '0;
  logic [2:0] rd = '0, rs = '0, rt = '0, fn = '0;
  logic [5:0] imm = '0;
  logic [8:0] off = '0;
  logic busy_a, done_a, wrap_a, busy_b, done_b, wrap_b;
  logic [8:0] cnt_a, cnt_b;
  int tests = 0, fails = 0, dones = 0;
  logic [15:0] wq[$];
  logic [7:0] aq[$], bq[$];
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] cs_a, cs_b;
`endif
  always #5 clk = ~clk;
  instr_encoder_loader_if ia ();
  instr_encoder_loader_if ib ();
  assign {ia.in_valid, ia.in_last, ia.in_opcode, ia.in_rd, ia.in_rs, ia.in_rt, ia.in_func, ia.in_imm, ia.in_offset, ia.mem_ready} =
         {v, last, op, rd, rs, rt, fn, imm, off, mr};
  assign {ib.in_valid, ib.in_last, ib.in_opcode, ib.in_rd, ib.in_rs, ib.in_rt, ib.in_func, ib.in_imm, ib.in_offset, ib.mem_ready} =
         {v, last, op, rd, rs, rt, fn, imm, off, mr};
  instr_encoder_loader dut_a (
    .clk(clk), .reset(reset), .start(start), .bus(ia),
    .busy(busy_a), .done(done_a), .count(cnt_a), .addr_wrap(wrap_a)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(cs_a)
`endif
  );
  instr_encoder_loader #(.BASE_ADDR(8'hFE)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bus(ib),
    .busy(busy_b), .done(done_b), .count(cnt_b), .addr_wrap(wrap_b)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(cs_b)
`endif
  );
  always @(posedge clk) begin
    if (ia.mem_we && ia.mem_ready) begin
      wq.push_back(ia.mem_wdata);
      aq.push_back(ia.mem_addr);
    end
    if (ib.mem_we && ib.mem_ready) bq.push_back(ib.mem_addr);
    if (done_a) dones++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic send(input logic [3:0] o, input logic [2:0] d, s, t, f, input logic [5:0] i, input logic [8:0] of, input logic l);
    int n;
    {op, rd, rs, rt, fn, imm, off, last, v} = {o, d, s, t, f, i, of, l, 1'b1};
    n = 0;
    while (!ia.in_ready && n < 50) begin
      tick;
      n++;
    end
    chk("accept_timeout", 32'(ia.in_ready), 1);
    tick;
    v = 1'b0;
    last = 1'b0;
  endtask
  task automatic wait_done;
    int n;
    n = 0;
    while (!done_a && n < 100) begin
      tick;
      n++;
    end
    chk("done_seen", 32'(done_a), 1);
    tick;
    chk("done_one_cycle", 32'(done_a), 0);
  endtask
  task automatic clear_q;
    wq.delete();
    aq.delete();
    bq.delete();
  endtask
  initial begin
    tick;
    tick;
    reset = 1'b0;
    chk("rst_in_ready", 32'(ia.in_ready), 0);
    chk("rst_mem_we", 32'(ia.mem_we), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_wrap", 32'(wrap_a), 0);
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_addr_a", 32'(ia.mem_addr), 32'h00);
    chk("rst_addr_b", 32'(ib.mem_addr), 32'hFE);
    chk("rst_wdata", 32'(ia.mem_wdata), 0);
    // tuple with in_last offered in IDLE is never accepted and must not matter
    {v, last} = 2'b11;
    tick;
    {v, last} = 2'b00;
    chk("idle_ignore_last", 32'(busy_a), 0);
    // 1: single R-type
    clear_q();
    pulse_start();
    chk("load_busy", 32'(busy_a), 1);
    chk("load_in_ready", 32'(ia.in_ready), 1);
    send(4'd0, 3'd1, 3'd2, 3'd3, 3'd5, 6'd0, 9'd0, 1'b1);
    wait_done();
    chk("t1_nwords", wq.size(), 1);
    chk("t1_word", 32'(wq[0]), 32'h029D);
    chk("t1_addr", 32'(aq[0]), 32'h00);
    chk("t1_count", 32'(cnt_a), 1);
    chk("t1_dones", dones, 1);
    chk("t1_idle", 32'(busy_a), 0);
    // 2: R, J, I in one load; start mid-load ignored; dut_b wraps FE,FF,00
    clear_q();
    pulse_start();
    send(4'd0, 3'd1, 3'd2, 3'd3, 3'd5, 6'd0, 9'd0, 1'b0);
    pulse_start();
    send(4'd1, 3'd0, 3'd0, 3'd0, 3'd2, 6'd0, 9'h1FF, 1'b0);
    send(4'd3, 3'd0, 3'd4, 3'd7, 3'd0, 6'h2A, 9'd0, 1'b1);
    wait_done();
    chk("t2_nwords", wq.size(), 3);
    chk("t2_w0", 32'(wq[0]), 32'h029D);
    chk("t2_w1", 32'(wq[1]), 32'h1FFA);
    chk("t2_w2", 32'(wq[2]), 32'h39EA);
    chk("t2_a0", 32'(aq[0]), 0);
    chk("t2_a1", 32'(aq[1]), 1);
    chk("t2_a2", 32'(aq[2]), 2);
    chk("t2_count", 32'(cnt_a), 3);
    chk("t2_wrap_a", 32'(wrap_a), 0);
    chk("t4_nwords_b", bq.size(), 3);
    chk("t4_b0", 32'(bq[0]), 32'hFE);
    chk("t4_b1", 32'(bq[1]), 32'hFF);
    chk("t4_b2", 32'(bq[2]), 32'h00);
    chk("t4_wrap_b", 32'(wrap_b), 1);
    chk("t4_count_b", 32'(cnt_b), 3);
`ifdef LOADER_CHECKSUM_EN
    chk("t6_checksum", 32'(cs_a), 32'(16'h029D ^ 16'h1FFA ^ 16'h39EA));
`endif
    // 3: back-pressure with a full FIFO, then drain six words in order
    clear_q();
    mr = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) send(4'd3, 3'd0, 3'd0, 3'd0, 3'd0, 6'(i), 9'd0, 1'b0);
    chk("t3_full_ready", 32'(ia.in_ready), 0);
    chk("t3_stall_we", 32'(ia.mem_we), 1);
    chk("t3_stall_wdata", 32'(ia.mem_wdata), 32'h3000);
    chk("t3_no_writes", wq.size(), 0);
    mr = 1'b1;
    send(4'd3, 3'd0, 3'd0, 3'd0, 3'd0, 6'd4, 9'd0, 1'b0);
    send(4'd3, 3'd0, 3'd0, 3'd0, 3'd0, 6'd5, 9'd0, 1'b1);
    wait_done();
    chk("t3_nwords", wq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t3_word", 32'(wq[i]), 32'h3000 + 32'(i));
      chk("t3_addr", 32'(aq[i]), 32'(i));
    end
    chk("t3_count", 32'(cnt_a), 6);
    // 5: reset with two words buffered, then reload
    clear_q();
    mr = 1'b0;
    pulse_start();
    send(4'd3, 3'd0, 3'd0, 3'd0, 3'd0, 6'd1, 9'd0, 1'b0);
    send(4'd3, 3'd0, 3'd0, 3'd0, 3'd0, 6'd2, 9'd0, 1'b0);
    chk("t5_pre_we", 32'(ia.mem_we), 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t5_we", 32'(ia.mem_we), 0);
    chk("t5_in_ready", 32'(ia.in_ready), 0);
    chk("t5_count", 32'(cnt_a), 0);
    chk("t5_busy", 32'(busy_a), 0);
    mr = 1'b1;
    tick;
    chk("t5_flushed", wq.size(), 0);
    pulse_start();
    send(4'd0, 3'd1, 3'd2, 3'd3, 3'd5, 6'd0, 9'd0, 1'b1);
    wait_done();
    chk("t5_nwords", wq.size(), 1);
    chk("t5_word", 32'(wq[0]), 32'h029D);
    chk("t5_addr", 32'(aq[0]), 0);
    chk("t5_count_after", 32'(cnt_a), 1);
    chk("t5_wrap_b_cleared", 32'(wrap_b), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
